adc_capture_arbiter: RTL
========================

ADC_CAPTURE_ARBITER -- requirements
Module: adc_capture_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 3: number of ADC channels.
REQ-002 SHALL have parameter DW, default 32: sample width.
REQ-003 SHALL have parameter AW, default 9: SRAM word address width, giving 512 words per bank.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, driven by wb_clk_i.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start_i, input, 1 bit: capture start pulse.
REQ-007 SHALL have port stop_i, input, 1 bit: capture abort pulse.
REQ-008 SHALL have port depth_i, input, AW+1 bits: words per bank; 0 means 2^AW.
REQ-009 SHALL have port ch_en_i, input, NCH bits: channel capture enables.
REQ-010 SHALL have port adc_dvalid_i, input, NCH bits: single-cycle sample strobes from the sinc3 filters.
REQ-011 SHALL have port adc_dat_i, input, NCH*DW bits: channel samples packed, channel 0 in the LSBs.
REQ-012 SHALL have port bank_clr_i, input, 2 bits: software release of a full bank.
REQ-013 SHALL have port mem_wenb_o, output, 2 bits: per-bank write strobe, active-low; drives csb0 and web0.
REQ-014 SHALL have port mem_waddr_o, output, AW bits: write address.
REQ-015 SHALL have port mem_data_o, output, DW bits: write data.
REQ-016 SHALL have port wmask_o, output, 4 bits: byte mask, constant 4'hF.
REQ-017 SHALL have port bank_full_o, output, 2 bits: bank holds depth words not yet released.
REQ-018 SHALL have port busy_o, output, 1 bit: state is not IDLE.
REQ-019 SHALL have port overflow_o, output, 1 bit: sticky sample-drop flag.
REQ-020 SHALL have port done_o, output, 1 bit: one-cycle pulse when a bank fills.

Function
REQ-021 SHALL implement states IDLE, RUN and WAIT_BANK.
REQ-022 SHALL, on start_i in IDLE: go to RUN, latch depth_i, select bank 0, set address 0, and clear overflow_o, pending flags and bank_full_o.
REQ-023 SHALL ignore start_i outside IDLE.
REQ-024 SHALL, on stop_i in any state: go to IDLE on the next edge, clear all pending flags, and issue no further writes; bank_full_o is retained.
REQ-025 SHALL give stop_i priority when start_i and stop_i are asserted together.
REQ-026 SHALL give each channel one pending register (flag plus data); a strobe on an enabled channel in RUN or WAIT_BANK loads it.
REQ-027 SHALL, when a strobe arrives while that channel's flag is set and the channel is not granted that cycle, drop the new sample, keep the old one, and set overflow_o.
REQ-028 SHALL, when a strobe arrives in the same cycle its channel is granted, reload the pending register without flagging overflow.
REQ-029 SHALL, in RUN, grant at most one pending channel per cycle using round-robin starting after the last granted channel; after reset the first grant goes to channel 0.
REQ-030 SHALL register all outputs; a grant drives mem_wenb_o[bank] low for exactly one cycle with the current address and data.
REQ-031 SHALL, with no contention, drive mem_wenb_o low in the cycle following the second rising edge after the edge that samples adc_dvalid_i.
REQ-032 SHALL, when a write lands on address depth-1: set bank_full_o[bank], pulse done_o, reset the address to 0, and toggle the bank.
REQ-033 SHALL, if the new bank is already full, go to WAIT_BANK; no grants occur there and pending data is held, with overflow as in REQ-027.
REQ-034 SHALL, on bank_clr_i[b], clear bank_full_o[b]; if the block is in WAIT_BANK and b is the selected bank, it returns to RUN on the next edge.
REQ-035 SHALL let a full-set event win over bank_clr_i for the same bank in the same cycle.
REQ-036 SHALL write sample data unmodified; the address counter never exceeds depth-1.
REQ-037 SHALL keep channels with ch_en_i low from loading; a channel already pending still drains.

Reset
REQ-038 SHALL, while rst_n is low, asynchronously force: state IDLE, mem_wenb_o 2'b11, mem_waddr_o 0, mem_data_o 0, bank_full_o 0, busy_o 0, overflow_o 0, done_o 0, pending flags 0, round-robin pointer to the last channel.
REQ-039 SHALL allow reset mid-capture to abort it with no write strobe emitted after rst_n falls.

Structure
REQ-040 SHALL take from a shared package vco_adc_pkg: the state enum, and the constants NCH, DW, AW and WMASK_ALL.
REQ-041 SHALL use one sub-module, rr_arbiter (NCH-wide request/grant with a rotating pointer).

Verification
REQ-042 SHALL cover single channel, depth 4, four ch0 strobes 8 cycles apart -> bank0 writes at addresses 0..3, bank_full_o=2'b01, done_o pulsed once, next write at bank1 address 0.
REQ-043 SHALL cover all three channels strobing in the same cycle -> three consecutive writes in order ch0, ch1, ch2, and overflow_o stays 0.
REQ-044 SHALL cover ch1 strobing on two consecutive cycles while ch0 and ch2 are pending -> second sample dropped and overflow_o=1 until the next start_i.
REQ-045 SHALL cover depth 2 with both banks filled -> WAIT_BANK with no strobes; bank_clr_i=2'b01 -> RUN and the next write at bank0 address 0.
REQ-046 SHALL cover rst_n pulled low during a write cycle -> mem_wenb_o=2'b11 immediately and all outputs at their reset values.
REQ-047 SHALL cover stop_i with two samples pending -> IDLE next cycle, no further writes, bank_full_o unchanged.

Source files
------------

// File: rtl/vco_adc_pkg.sv
// Shared types and constants for the VCO-ADC capture path.
package vco_adc_pkg;
  localparam int NCH = 3;
  localparam int DW  = 32;
  localparam int AW  = 9;
  localparam logic [3:0] WMASK_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_BANK
  } cap_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter; search starts one past the last granted index.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);
  logic [PW-1:0] ptr_q;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(ptr_q) + i) % N;
      if (req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = PW'(idx);
      end
    end
    gnt_o = '0;
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ptr_q <= PW'(N - 1);
    else if (adv_i && gnt_vld_o) ptr_q <= gnt_idx_o;
  end
endmodule

// File: rtl/adc_capture_arbiter.sv
// Multi-channel ADC capture into two ping-pong SRAM banks. Pending register per
// channel, round-robin grant stage, then a registered write port.
module adc_capture_arbiter
  import vco_adc_pkg::cap_state_e, vco_adc_pkg::ST_IDLE, vco_adc_pkg::ST_RUN,
         vco_adc_pkg::ST_WAIT_BANK, vco_adc_pkg::WMASK_ALL;
#(
  parameter int NCH = vco_adc_pkg::NCH,
  parameter int DW  = vco_adc_pkg::DW,
  parameter int AW  = vco_adc_pkg::AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [AW:0]       depth_i,
  input  logic [NCH-1:0]    ch_en_i,
  input  logic [NCH-1:0]    adc_dvalid_i,
  input  logic [NCH*DW-1:0] adc_dat_i,
  input  logic [1:0]        bank_clr_i,
  output logic [1:0]        mem_wenb_o,
  output logic [AW-1:0]     mem_waddr_o,
  output logic [DW-1:0]     mem_data_o,
  output logic [3:0]        wmask_o,
  output logic [1:0]        bank_full_o,
  output logic              busy_o,
  output logic              overflow_o,
  output logic              done_o
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  cap_state_e               state_q, state_d;
  logic [AW-1:0]            last_q, last_d, addr_q, addr_d;
  logic                     bank_q, bank_d;
  logic [1:0]               full_q, full_d;
  logic                     ovf_q, ovf_d, done_q, busy_q;
  logic [NCH-1:0]           pvld_q, pvld_d;
  logic [NCH-1:0][DW-1:0]   pdat_q, pdat_d;
  logic                     wr_vld_q, wr_bank_q;
  logic [AW-1:0]            wr_addr_q, waddr_q;
  logic [DW-1:0]            wr_dat_q, wdat_q;
  logic [1:0]               wenb_q;

  logic                     go, grant_ok, take, wrap, capt;
  logic [NCH-1:0]           gnt, stb, hit;
  logic [PW-1:0]            gnt_idx;
  logic                     gnt_vld;

  assign go       = start_i && !stop_i && (state_q == ST_IDLE);
  assign grant_ok = (state_q == ST_RUN) && !stop_i;
  assign take     = grant_ok && gnt_vld;
  assign wrap     = take && (addr_q == last_q);
  assign capt     = (state_q != ST_IDLE) && !stop_i;
  assign stb      = {NCH{capt}} & adc_dvalid_i & ch_en_i;
  assign hit      = take ? gnt : '0;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (pvld_q),
    .adv_i     (grant_ok),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    full_d  = full_q & ~bank_clr_i;
    ovf_d   = ovf_q;
    pvld_d  = pvld_q;
    pdat_d  = pdat_q;
    if (take) addr_d = wrap ? '0 : addr_q + 1'b1;
    // A fill on the same cycle as a software clear keeps the bank full.
    if (wrap) begin
      full_d[bank_q] = 1'b1;
      bank_d         = ~bank_q;
    end
    for (int c = 0; c < NCH; c++) begin
      if (hit[c]) pvld_d[c] = 1'b0;
      if (stb[c]) begin
        if (!pvld_q[c] || hit[c]) begin
          pvld_d[c] = 1'b1;
          pdat_d[c] = adc_dat_i[c*DW +: DW];
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
    unique case (state_q)
      ST_IDLE: if (go) begin
        state_d = ST_RUN;
        last_d  = AW'(depth_i - 1'b1);
        addr_d  = '0;
        bank_d  = 1'b0;
        full_d  = '0;
        ovf_d   = 1'b0;
        pvld_d  = '0;
      end
      ST_RUN:       if (wrap && full_d[~bank_q]) state_d = ST_WAIT_BANK;
      ST_WAIT_BANK: if (bank_clr_i[bank_q])      state_d = ST_RUN;
      default:      state_d = ST_IDLE;
    endcase
    if (stop_i) begin
      state_d = ST_IDLE;
      pvld_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= '0;
      addr_q    <= '0;
      bank_q    <= 1'b0;
      full_q    <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      pvld_q    <= '0;
      pdat_q    <= '0;
      wr_vld_q  <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
      wenb_q    <= 2'b11;
      waddr_q   <= '0;
      wdat_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      bank_q   <= bank_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      done_q   <= wrap;
      busy_q   <= (state_d != ST_IDLE);
      pvld_q   <= pvld_d;
      pdat_q   <= pdat_d;
      wr_vld_q <= take;
      if (take) begin
        wr_bank_q <= bank_q;
        wr_addr_q <= addr_q;
        wr_dat_q  <= pdat_q[gnt_idx];
      end
      // An in-flight grant is dropped if a stop lands before it reaches the port.
      if (wr_vld_q && !stop_i) begin
        wenb_q  <= wr_bank_q ? 2'b01 : 2'b10;
        waddr_q <= wr_addr_q;
        wdat_q  <= wr_dat_q;
      end else begin
        wenb_q  <= 2'b11;
      end
    end
  end

  assign mem_wenb_o  = wenb_q;
  assign mem_waddr_o = waddr_q;
  assign mem_data_o  = wdat_q;
  assign wmask_o     = WMASK_ALL;
  assign bank_full_o = full_q;
  assign busy_o      = busy_q;
  assign overflow_o  = ovf_q;
  assign done_o      = done_q;
endmodule
